// File: rtl/anc_invert_arbiter_pkg.sv
// anc_pkg: shared widths, channel indices and FSM state type for the invert arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package anc_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/anc_invert_arbiter_if.sv
// anc_invert_arbiter_if: two sample input channels plus one result output channel.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel; master drives samples, slave drives results.
interface anc_invert_arbiter_if
  import anc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                     s0_valid;
  logic signed [DATA_W-1:0] s0_data;
  logic                     s0_ready;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_data;
  logic                     s1_ready;
  logic                     m_valid;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_ch;
  logic                     m_ready;

  // Sample producer / result consumer side.
  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, m_ready,
    input  s0_ready, s1_ready, m_valid, m_data, m_ch
  );

  // Arbiter side.
  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, m_ready,
    output s0_ready, s1_ready, m_valid, m_data, m_ch
  );

endinterface

// File: rtl/anc_invert_arbiter_negate_sat.sv
// anc_negate_sat: combinational two's-complement negation with most-negative detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; build option ANC_INVERT_SAT_EN clamps -MIN to MAX instead of wrapping.
module anc_negate_sat
  import anc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_o,
  output logic                     is_min_o
);

  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

  assign is_min_o = (din_i == MIN_V);

  // Negate; the most-negative input either wraps to itself or clamps to MAX.
  always_comb begin
    dout_o = -din_i;
`ifdef ANC_INVERT_SAT_EN
    if (is_min_o) begin
      dout_o = MAX_V;
    end
`else
    if (is_min_o) begin
      dout_o = MIN_V;
    end
`endif
  end

endmodule

// File: rtl/anc_invert_arbiter.sv
// anc_invert_arbiter: round-robin two-channel arbiter feeding one shared negator and result register.
// Latency: 1 cycle from accepted sample to m_valid; sustains one result per cycle.
// Backpressure: sN_ready low while the result register is held (m_valid && !m_ready); option ANC_INVERT_SAT_EN.
module anc_invert_arbiter
  import anc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  anc_invert_arbiter_if.slave bus,
  output logic [CNT_W-1:0]    ovf_cnt
);

  state_e                   state_q, state_d;
  logic                     rr_q, rr_d;          // channel that wins a tie next
  logic signed [DATA_W-1:0] m_data_q;
  logic                     m_ch_q;
  logic [CNT_W-1:0]         ovf_q, ovf_d;

  logic                     space;
  logic                     gnt;
  logic                     acc;
  logic signed [DATA_W-1:0] sel_data;
  logic signed [DATA_W-1:0] neg_data;
  logic                     is_min;

  anc_negate_sat #(.DATA_W(DATA_W)) u_neg (
    .din_i    (sel_data),
    .dout_o   (neg_data),
    .is_min_o (is_min)
  );

  // State register: EMPTY/FULL mirrors the output register occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill on accept, drain only when no refill happens the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (acc) state_d = ST_FULL;
      ST_FULL:  if (bus.m_ready && !acc) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Outputs: grant selection, per-channel ready and the accept strobe.
  always_comb begin
    space = (state_q == ST_EMPTY) || bus.m_ready;
    if (bus.s0_valid && bus.s1_valid) begin
      gnt = rr_q;
    end else if (bus.s1_valid) begin
      gnt = CH1;
    end else if (bus.s0_valid) begin
      gnt = CH0;
    end else begin
      gnt = rr_q;
    end
    bus.s0_ready = rst_n && space && (gnt == CH0);
    bus.s1_ready = rst_n && space && (gnt == CH1);
    acc          = (bus.s0_valid && bus.s0_ready) || (bus.s1_valid && bus.s1_ready);
    sel_data     = (gnt == CH1) ? bus.s1_data : bus.s0_data;
    bus.m_valid  = (state_q == ST_FULL);
    bus.m_data   = m_data_q;
    bus.m_ch     = m_ch_q;
  end

  // Round-robin pointer and saturating overflow count, both advanced only on accept.
  always_comb begin
    rr_d  = rr_q;
    ovf_d = ovf_q;
    if (acc) begin
      rr_d = ~gnt;
      if (is_min && (ovf_q != {CNT_W{1'b1}})) begin
        ovf_d = ovf_q + CNT_W'(1);
      end
    end
  end

  // Result register, pointer and counter; result payload reloads only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
      m_ch_q   <= CH0;
      rr_q     <= CH0;
      ovf_q    <= '0;
    end else begin
      if (acc) begin
        m_data_q <= neg_data;
        m_ch_q   <= gnt;
      end
      rr_q  <= rr_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_anc_invert_arbiter.sv
// tb_anc_invert_arbiter: directed stimulus with a result scoreboard for the invert arbiter.
// Latency: expects results one cycle after acceptance.
// Backpressure: exercises m_ready stalls and reset mid-flight.
module tb_anc_invert_arbiter;
  import anc_pkg::*;

  localparam int DW = 64;
  localparam logic [DW-1:0] MINV = 64'h8000_0000_0000_0000;
`ifdef ANC_INVERT_SAT_EN
  localparam logic [DW-1:0] EXP_MIN = 64'h7FFF_FFFF_FFFF_FFFF;
`else
  localparam logic [DW-1:0] EXP_MIN = 64'h8000_0000_0000_0000;
`endif

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] ovf_cnt;
  logic [1:0]  ovf_cnt2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  anc_invert_arbiter_if #(.DATA_W(DW)) bus ();
  anc_invert_arbiter_if #(.DATA_W(DW)) bus2 ();

  anc_invert_arbiter #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_cnt(ovf_cnt)
  );

  anc_invert_arbiter #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .ovf_cnt(ovf_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Present one sample on a channel until it is taken (bounded), then withdraw it.
  task automatic send(input logic ch, input logic [DW-1:0] d);
    int n = 0;
    logic got = 1'b0;
    if (ch == CH0) begin bus.s0_valid = 1'b1; bus.s0_data = d; end
    else           begin bus.s1_valid = 1'b1; bus.s1_data = d; end
    while (!got && n < 20) begin
      @(negedge clk);
      got = (ch == CH0) ? bus.s0_ready : bus.s1_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    chk("send_accept", {63'd0, got}, 64'd1);
    chk("latency_m_valid", {63'd0, bus.m_valid}, 64'd1);
  endtask

  // Hold both channels valid until n transfers are taken; report cycles used.
  task automatic run_both(input int n, output int nacc, output int cyc);
    nacc = 0;
    cyc = 0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    while (nacc < n && cyc < 20) begin
      @(negedge clk);
      if (bus.s0_valid && bus.s0_ready) nacc++;
      if (bus.s1_valid && bus.s1_ready) nacc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Scoreboard monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch %0d data %h, none expected", bus.m_ch, bus.m_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_ch", {63'd0, bus.m_ch}, {63'd0, e.ch});
        chk("out_data", bus.m_data, e.data);
      end
    end
  end

  initial begin
    int nacc;
    int cyc;
    int n;
    logic [1:0] exp2;

    bus.s0_valid = 1'b0; bus.s0_data = '0;
    bus.s1_valid = 1'b0; bus.s1_data = '0;
    bus.m_ready = 1'b1;
    bus2.s0_valid = 1'b0; bus2.s0_data = '0;
    bus2.s1_valid = 1'b0; bus2.s1_data = '0;
    bus2.m_ready = 1'b1;

    // Reset state, with downstream ready so readiness is held low only by reset.
    #2;
    chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("rst_m_data", bus.m_data, 64'd0);
    chk("rst_m_ch", {63'd0, bus.m_ch}, 64'd0);
    chk("rst_ovf", {48'd0, ovf_cnt}, 64'd0);
    chk("rst_s0_ready", {63'd0, bus.s0_ready}, 64'd0);
    chk("rst_s1_ready", {63'd0, bus.s1_ready}, 64'd0);
    chk("rst_ovf2", {62'd0, ovf_cnt2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single sample on channel 0, then one on channel 1.
    push(CH0, 64'hFFFF_FFFF_FFFF_FFFB);
    send(CH0, 64'd5);
    push(CH1, 64'hFFFF_FFFF_FFFF_FFF9);
    send(CH1, 64'd7);

    // Both valid: alternate 0,1,0,1 at one result per cycle.
    bus.s0_data = 64'd1;
    bus.s1_data = 64'd2;
    push(CH0, 64'hFFFF_FFFF_FFFF_FFFF);
    push(CH1, 64'hFFFF_FFFF_FFFF_FFFE);
    push(CH0, 64'hFFFF_FFFF_FFFF_FFFF);
    push(CH1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_both(4, nacc, cyc);
    chk("alt_count", 64'(nacc), 64'd4);
    chk("alt_cycles", 64'(cyc), 64'd4);

    // Stall: result held stable and both readies low for 4 cycles.
    bus.m_ready = 1'b0;
    bus.s1_valid = 1'b0;
    bus.s0_data = 64'd3;
    push(CH0, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (4) begin
      @(negedge clk);
      chk("stall_m_valid", {63'd0, bus.m_valid}, 64'd1);
      chk("stall_m_data", bus.m_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("stall_m_ch", {63'd0, bus.m_ch}, 64'd1);
      chk("stall_s0_ready", {63'd0, bus.s0_ready}, 64'd0);
      chk("stall_s1_ready", {63'd0, bus.s1_ready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("release_s0_ready", {63'd0, bus.s0_ready}, 64'd1);
    @(posedge clk); #1;
    bus.s0_valid = 1'b0;

    // Most-negative input on channel 1: wrap or clamp, counted either way.
    push(CH1, EXP_MIN);
    send(CH1, MINV);
    @(posedge clk); #1;
    chk("ovf_one", {48'd0, ovf_cnt}, 64'd1);

    // Reset asserted mid-cycle with a result held; the result is discarded.
    bus.m_ready = 1'b0;
    send(CH0, 64'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("arst_m_data", bus.m_data, 64'd0);
    chk("arst_ovf", {48'd0, ovf_cnt}, 64'd0);
    chk("arst_s0_ready", {63'd0, bus.s0_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.s0_data = 64'd11;
    bus.s1_data = 64'd12;
    push(CH0, 64'hFFFF_FFFF_FFFF_FFF5);
    push(CH1, 64'hFFFF_FFFF_FFFF_FFF4);
    #1;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    #1;
    chk("post_rst_s0_first", {63'd0, bus.s0_ready}, 64'd1);
    chk("post_rst_s1_wait", {63'd0, bus.s1_ready}, 64'd0);
    run_both(2, nacc, cyc);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    chk("post_rst_count", 64'(nacc), 64'd2);

    // Narrow counter saturates at 3 after four most-negative inputs.
    bus2.s0_data = MINV;
    for (int i = 0; i < 4; i++) begin
      bus2.s0_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!bus2.s0_ready) begin
          @(posedge clk); #1;
        end
      end while (!bus2.s0_ready && n < 20);
      if (bus2.s0_ready) begin
        @(posedge clk); #1;
      end
      exp2 = (i < 3) ? 2'(i + 1) : 2'd3;
      chk("ovf2_sat", {62'd0, ovf_cnt2}, {62'd0, exp2});
    end
    bus2.s0_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anc_invert_arbiter.md
ANC_INVERT_ARBITER -- requirements
Module: anc_invert_arbiter

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, signed sample width.
REQ-002 SHALL provide parameter CNT_W, default 16, overflow-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port s0_valid  input  1  channel-0 sample valid.
REQ-006 SHALL have port s0_data  input  DATA_W  channel-0 signed sample.
REQ-007 SHALL have port s0_ready  output  1  channel-0 sample accepted this cycle when high with s0_valid.
REQ-008 SHALL have ports s1_valid, s1_data, s1_ready with the same widths and meaning for channel 1.
REQ-009 SHALL have port m_valid  output  1  inverted result valid.
REQ-010 SHALL have port m_data  output  DATA_W  signed result, -(sample).
REQ-011 SHALL have port m_ch  output  1  source channel of m_data.
REQ-012 SHALL have port m_ready  input  1  downstream accepts result.
REQ-013 SHALL have port ovf_cnt  output  CNT_W  count of inputs equal to -2^(DATA_W-1).

Function
REQ-014 SHALL share one negation datapath between channels 0 and 1; at most one sample accepted per cycle.
REQ-015 SHALL hold a single-entry output register; "space" = !m_valid || m_ready.
REQ-016 SHALL grant, when space: only requesting channel if one valid; if both valid, channel not granted last (round-robin pointer).
REQ-017 SHALL assert sN_ready only for the granted channel and only when space; sN_ready combinationally independent of sN_valid of the other channel beyond the grant rule.
REQ-018 SHALL update the round-robin pointer only on an accepted transfer.
REQ-019 SHALL register m_data = -data, m_ch = channel, m_valid = 1 on the cycle after acceptance (latency 1).
REQ-020 SHALL keep m_valid, m_data, m_ch stable while m_valid && !m_ready.
REQ-021 SHALL clear m_valid on m_ready when no new acceptance that cycle; simultaneous drain and accept reloads the register (full throughput, one result per cycle).
REQ-022 SHALL increment ovf_cnt on each accepted sample equal to -2^(DATA_W-1), saturating at all-ones.
REQ-023 SHALL implement states EMPTY (m_valid=0) and FULL (m_valid=1): EMPTY->FULL on accept; FULL->EMPTY on m_ready without accept; FULL->FULL on accept or stall.

Reset
REQ-024 SHALL on rst_n low immediately force m_valid=0, m_data=0, m_ch=0, ovf_cnt=0, round-robin pointer favouring channel 0.
REQ-025 SHALL discard any in-flight result when reset asserts mid-operation; first grant after release follows REQ-016 with channel 0 priority.
REQ-026 SHALL drive s0_ready and s1_ready low while rst_n is low.

Configuration
REQ-027 SHALL, with macro ANC_INVERT_SAT_EN defined, output 2^(DATA_W-1)-1 for input -2^(DATA_W-1).
REQ-028 SHALL, without ANC_INVERT_SAT_EN, output the two's-complement wrap (-2^(DATA_W-1)); ovf_cnt counts in both builds.

Structure
REQ-029 SHALL place DATA_W default, CNT_W default, and channel-index constants in shared package anc_pkg.
REQ-030 SHALL isolate negation/saturation in one combinational sub-module anc_negate_sat; arbiter, output register, counter in the top.

Verification
REQ-031 SHALL test: s0_valid=1, s0_data=5, m_ready=1 -> next cycle m_valid=1, m_data=-5, m_ch=0.
REQ-032 SHALL test: both valid continuously, m_ready=1, s0_data=1, s1_data=2 -> m_ch alternates 0,1,0,1; one result per cycle.
REQ-033 SHALL test: m_ready=0 for 4 cycles with m_valid=1 -> m_data/m_ch stable, s0_ready=s1_ready=0; release -> next sample accepted same cycle.
REQ-034 SHALL test: s1_data=0x8000_0000_0000_0000 -> m_data=0x7FFF_FFFF_FFFF_FFFF with ANC_INVERT_SAT_EN, 0x8000_0000_0000_0000 without; ovf_cnt=1.
REQ-035 SHALL test: rst_n pulsed low while m_valid=1 -> m_valid=0, ovf_cnt=0 asynchronously; after release both valid -> channel 0 granted first.
REQ-036 SHALL test: CNT_W=2, four overflow inputs -> ovf_cnt saturates at 3.
